// File: rtl/nn_pkg.sv
// Shared types and helpers for the dense-layer sequencing blocks.
package nn_pkg;

    localparam int unsigned FRAC_BITS = 15;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT_RES,
        S_DONE
    } state_t;

    // Address width for n entries, never narrower than one bit.
    function automatic int unsigned aw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// Input/neuron counters and weight base register for layer_feeder.
module feeder_addr_gen
    import nn_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 784,
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned ACT_AW      = aw(NUM_INPUTS),
    parameter int unsigned W_AW        = aw(NUM_INPUTS * NUM_NEURONS),
    parameter int unsigned N_AW        = aw(NUM_NEURONS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              step_i,
    input  logic              next_n_i,
    output logic              last_o,
    output logic              n_last_o,
    output logic [ACT_AW-1:0] act_addr_o,
    output logic [W_AW-1:0]   w_addr_o,
    output logic [N_AW-1:0]   b_addr_o
);

    logic [ACT_AW-1:0] i_q, i_d;
    logic [N_AW-1:0]   n_q, n_d;
    logic [W_AW-1:0]   base_q, base_d;

    assign last_o     = (i_q == ACT_AW'(NUM_INPUTS - 1));
    assign n_last_o   = (n_q == N_AW'(NUM_NEURONS - 1));
    assign act_addr_o = i_q;
    // base_q tracks n*NUM_INPUTS so the weight address needs only an adder.
    assign w_addr_o   = base_q + W_AW'(i_q);
    assign b_addr_o   = n_q;

    always_comb begin
        i_d    = i_q;
        n_d    = n_q;
        base_d = base_q;
        if (clear_i) begin
            i_d    = '0;
            n_d    = '0;
            base_d = '0;
        end else begin
            if (step_i) begin
                i_d = last_o ? '0 : i_q + 1'b1;
            end
            if (next_n_i) begin
                n_d    = n_q + 1'b1;
                base_d = base_q + W_AW'(NUM_INPUTS);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q    <= '0;
            n_q    <= '0;
            base_q <= '0;
        end else begin
            i_q    <= i_d;
            n_q    <= n_d;
            base_q <= base_d;
        end
    end

endmodule

// File: rtl/layer_feeder.sv
// Streams one dense layer through a time-multiplexed neuron and stores each result.
module layer_feeder
    import nn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_INPUTS  = 784,
    parameter int unsigned NUM_NEURONS = 10,
    parameter int unsigned ACT_AW      = aw(NUM_INPUTS),
    parameter int unsigned W_AW        = aw(NUM_INPUTS * NUM_NEURONS),
    parameter int unsigned N_AW        = aw(NUM_NEURONS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ACT_AW-1:0]     act_addr,
    input  logic [DATA_WIDTH-1:0] act_data,
    output logic [W_AW-1:0]       w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [N_AW-1:0]       b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [DATA_WIDTH-1:0] nrn_data,
    output logic [DATA_WIDTH-1:0] nrn_weight,
    output logic [DATA_WIDTH-1:0] nrn_bias,
    output logic                  nrn_valid,
    input  logic [DATA_WIDTH-1:0] nrn_result,
    input  logic                  nrn_result_valid,
    output logic                  res_wr_en,
    output logic [N_AW-1:0]       res_addr,
    output logic [DATA_WIDTH-1:0] res_data
);

    state_t state_q, state_d;
    logic   valid_q;
    logic   wr_q;
    logic [N_AW-1:0]       res_addr_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic clear, step, next_n, capture, last_in, n_last;

    feeder_addr_gen #(
        .NUM_INPUTS (NUM_INPUTS),
        .NUM_NEURONS(NUM_NEURONS),
        .ACT_AW     (ACT_AW),
        .W_AW       (W_AW),
        .N_AW       (N_AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear),
        .step_i    (step),
        .next_n_i  (next_n),
        .last_o    (last_in),
        .n_last_o  (n_last),
        .act_addr_o(act_addr),
        .w_addr_o  (w_addr),
        .b_addr_o  (b_addr)
    );

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        step    = 1'b0;
        next_n  = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    clear   = 1'b1;
                end
            end
            S_STREAM: begin
                step = 1'b1;
                if (last_in) state_d = S_WAIT_RES;
            end
            S_WAIT_RES: begin
                if (nrn_result_valid) begin
                    capture = 1'b1;
                    if (n_last) begin
                        state_d = S_DONE;
                    end else begin
                        next_n  = 1'b1;
                        state_d = S_STREAM;
                    end
                end
            end
            S_DONE: begin
                clear   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            wr_q       <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_q == S_STREAM);
            wr_q    <= capture;
            if (capture) begin
                res_addr_q <= b_addr;
                res_data_q <= nrn_result;
            end
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign nrn_valid  = valid_q;
    // RAM data is gated so the neuron side reads zero whenever nothing is streamed.
    assign nrn_data   = valid_q ? act_data : '0;
    assign nrn_weight = valid_q ? w_data   : '0;
    assign nrn_bias   = busy    ? b_data   : '0;
    assign res_wr_en  = wr_q;
    assign res_addr   = res_addr_q;
    assign res_data   = res_data_q;

`ifndef SYNTHESIS
    stray_result_a: assert property (@(posedge clk) disable iff (rst)
        nrn_result_valid |-> (state_q == S_WAIT_RES))
        else $warning("nrn_result_valid seen outside WAIT_RES; ignored");
`endif

endmodule

// File: tb/tb_layer_feeder.sv
// Scoreboard bench for layer_feeder with RAM and neuron behavioural models.
module tb_layer_feeder;

    localparam int DW  = 16;
    localparam int NI  = 4;
    localparam int NN  = 2;
    localparam int AAW = 2;
    localparam int WAW = 3;
    localparam int NAW = 1;

    logic           clk = 1'b0;
    logic           rst, start, stray;
    logic           busy, done, nrn_valid, nrn_result_valid, res_wr_en;
    logic [AAW-1:0] act_addr;
    logic [WAW-1:0] w_addr;
    logic [NAW-1:0] b_addr, res_addr;
    logic [DW-1:0]  act_data, w_data, b_data;
    logic [DW-1:0]  nrn_data, nrn_weight, nrn_bias, nrn_result, res_data;

    logic [DW-1:0] act_mem [NI];
    logic [DW-1:0] w_mem   [NI*NN];
    logic [DW-1:0] b_mem   [NN];

    always #5 clk = ~clk;

    layer_feeder #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI),
        .NUM_NEURONS(NN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .act_addr        (act_addr),
        .act_data        (act_data),
        .w_addr          (w_addr),
        .w_data          (w_data),
        .b_addr          (b_addr),
        .b_data          (b_data),
        .nrn_data        (nrn_data),
        .nrn_weight      (nrn_weight),
        .nrn_bias        (nrn_bias),
        .nrn_valid       (nrn_valid),
        .nrn_result      (nrn_result),
        .nrn_result_valid(nrn_result_valid),
        .res_wr_en       (res_wr_en),
        .res_addr        (res_addr),
        .res_data        (res_data)
    );

    always @(posedge clk) begin
        act_data <= act_mem[act_addr];
        w_data   <= w_mem[w_addr];
        b_data   <= b_mem[b_addr];
    end

    // Neuron model: Q1.15 MAC, bias added at the last input, ReLU and clip to 16 bits.
    longint acc;
    int     cnt;
    logic   n_ov;
    logic [DW-1:0] n_out;

    function automatic longint prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    function automatic logic [DW-1:0] finish_q(input longint sum, input logic [DW-1:0] bias);
        longint t;
        t = (sum + (longint'($signed(bias)) <<< 15)) >>> 15;
        if (t < 0) return '0;
        if (t > 65535) return '1;
        return t[DW-1:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            acc <= 0; cnt <= 0; n_ov <= 1'b0; n_out <= '0;
        end else begin
            n_ov <= 1'b0;
            if (nrn_valid) begin
                if (cnt == NI - 1) begin
                    n_out <= finish_q(acc + prod(nrn_data, nrn_weight), nrn_bias);
                    n_ov  <= 1'b1;
                    acc   <= 0;
                    cnt   <= 0;
                end else begin
                    acc <= acc + prod(nrn_data, nrn_weight);
                    cnt <= cnt + 1;
                end
            end
        end
    end

    assign nrn_result       = n_out;
    assign nrn_result_valid = n_ov | stray;

    typedef struct {
        logic [NAW-1:0] a;
        logic [DW-1:0]  d;
    } exp_t;
    exp_t sb[$];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic push(input logic [NAW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (res_wr_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {31'd0, res_wr_en}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_addr", 32'(res_addr), 32'(e.a));
                chk("res_data", 32'(res_data), 32'(e.d));
            end
        end
        if (done) chk("done_with_wr", 32'(res_wr_en), 32'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        chk("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stray = 1'b0;
        for (int i = 0; i < NI; i++) act_mem[i] = 16'h4000;
        for (int i = 0; i < NI; i++) w_mem[i] = 16'h4000;
        for (int i = NI; i < NI*NN; i++) w_mem[i] = 16'hC000;
        b_mem[0] = 16'h0000;
        b_mem[1] = 16'h0000;

        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(nrn_valid), 0);
        chk("rst_wr", 32'(res_wr_en), 0);
        chk("rst_act_addr", 32'(act_addr), 0);
        chk("rst_w_addr", 32'(w_addr), 0);
        chk("rst_b_addr", 32'(b_addr), 0);
        chk("rst_res_addr", 32'(res_addr), 0);
        chk("rst_res_data", 32'(res_data), 0);
        rst = 1'b0;
        tick();

        // Cycle-accurate walk: 0.5*0.5*4 = 1.0 -> 0x8000; negative sum -> 0.
        push(1'b0, 16'h8000);
        push(1'b1, 16'h0000);
        start = 1'b1;
        tick();
        for (int c = 1; c <= 14; c++) begin
            if (c == 1) start = 1'b0;
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= 13));
            chk($sformatf("valid_c%0d", c), 32'(nrn_valid),
                32'((c >= 2 && c <= 5) || (c >= 8 && c <= 11)));
            chk($sformatf("done_c%0d", c), 32'(done), 32'(c == 13));
            chk($sformatf("b_addr_c%0d", c), 32'(b_addr), 32'(c >= 7 && c <= 13));
            if (c >= 1 && c <= 4) begin
                chk($sformatf("act_addr_c%0d", c), 32'(act_addr), 32'(c - 1));
                chk($sformatf("w_addr_c%0d", c), 32'(w_addr), 32'(c - 1));
            end
            if (c >= 7 && c <= 10) begin
                chk($sformatf("act_addr_c%0d", c), 32'(act_addr), 32'(c - 7));
                chk($sformatf("w_addr_c%0d", c), 32'(w_addr), 32'(c - 3));
            end
            if (c < 14) tick();
        end

        // Bias only: neuron 0 sum 0 with bias 0.25 -> 0x2000.
        for (int i = 0; i < NI; i++) w_mem[i] = 16'h0000;
        b_mem[0] = 16'h2000;
        push(1'b0, 16'h2000);
        push(1'b1, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        tick();
        chk("bias_idle", 32'(busy), 0);

        // start held high: one evaluation per IDLE entry.
        for (int r = 0; r < 2; r++) begin
            push(1'b0, 16'h2000);
            push(1'b1, 16'h0000);
        end
        start = 1'b1;
        tick();
        wait_done(100);
        tick();
        chk("held_idle_gap", 32'(busy), 0);
        tick();
        chk("held_restart", 32'(busy), 1);
        wait_done(100);
        start = 1'b0;
        tick();
        tick();
        chk("held_stop", 32'(busy), 0);

        // Reset in cycle 3 aborts with no write.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(nrn_valid), 0);
        chk("abort_act_addr", 32'(act_addr), 0);
        chk("abort_w_addr", 32'(w_addr), 0);
        chk("abort_wr", 32'(res_wr_en), 0);
        chk("abort_nrn_data", 32'(nrn_data), 0);
        repeat (8) tick();
        push(1'b0, 16'h2000);
        push(1'b1, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        tick();

        // Stray result pulses in IDLE and STREAM are ignored.
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk("stray_idle_busy", 32'(busy), 0);
        chk("stray_idle_wr", 32'(res_wr_en), 0);
        push(1'b0, 16'h2000);
        push(1'b1, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk("stray_stream_addr", 32'(act_addr), 2);
        chk("stray_stream_busy", 32'(busy), 1);
        wait_done(100);

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
